pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 50 +++++
 rtl/squash_counter.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 98 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   - per-stage control-bundle widths
//   - bit positions of the control signals inside the bundle
//   - default length of the post-redirect squash window
//   - the per-edge action encoding and its priority decoder
package pipe_pkg;

    // Control-bundle width carried by each inter-stage register.
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_CTRL_W  = 8;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_CTRL_W = 2;

    // Bit positions inside the control bundle.
    localparam int REGWRITE = 0;
    localparam int MEMTOREG = 1;
    localparam int MEMWRITE = 2;
    localparam int MEMREAD  = 3;
    localparam int BRANCH   = 4;
    localparam int ISJ      = 5;
    localparam int ISJAL    = 6;
    localparam int ISJR     = 7;

    // Bubbles forced after a taken branch/jump leaves EX.
    localparam int DEFAULT_SQUASH_N = 3;

    // Exactly one of these happens on every rising clock edge.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_STALL,
        ACT_SQUASH,
        ACT_LOAD
    } stage_action_e;

    // Priority: reset > flush > stall > squash > load.
    function automatic stage_action_e decode_action(
        input logic rst,
        input logic flush,
        input logic stall,
        input logic squash
    );
        if (rst)         return ACT_RESET;
        else if (flush)  return ACT_FLUSH;
        else if (stall)  return ACT_STALL;
        else if (squash) return ACT_SQUASH;
        else             return ACT_LOAD;
    endfunction

endpackage

// File: rtl/squash_counter.sv
// Down-counter that tracks the remaining bubbles of a squash window.
//   clk     in  : rising-edge clock
//   rst     in  : synchronous active-high reset, clears the count
//   clear   in  : clears the count (flush)
//   hold    in  : freezes the count (stall)
//   load    in  : starts a window, count <- N
//   cnt     out : current count
//   nonzero out : window active
// When none of the controls is active the count decrements until it hits 0.
module squash_counter #(
    parameter int N     = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hold,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(N);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst || clear) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign nonzero = (cnt != '0);

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with stall, flush and a post-redirect
// squash window.
//   clk          in  : rising-edge clock
//   rst          in  : synchronous active-high reset
//   stall_i      in  : hold all state
//   flush_i      in  : replace contents with a bubble (overrides stall)
//   redirect_i   in  : incoming instruction is a taken branch/jump
//   valid_i      in  : incoming slot holds a real instruction
//   ctrl_i       in  : incoming control bundle
//   data_i       in  : incoming payload
//   valid_o      out : registered valid
//   ctrl_o       out : registered control, zero whenever valid_o is 0
//   data_o       out : registered payload (not cleared on bubbles)
//   squash_o     out : squash window active
//   squash_cnt_o out : remaining bubbles in the window
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CTRL_W   = 8,
    parameter int SQUASH_N = DEFAULT_SQUASH_N,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [WIDTH-1:0]  data_o,
    output logic              squash_o,
    output logic [CNT_W-1:0]  squash_cnt_o
);

    if ((2 ** CNT_W) - 1 < SQUASH_N) begin : g_cnt_w_too_narrow
        $error("pipe_stage_reg: CNT_W cannot hold SQUASH_N");
    end

    stage_action_e action;
    logic          cnt_load;

    assign action = decode_action(rst, flush_i, stall_i, squash_o);

    // Only a real redirecting instruction that is actually loaded opens a
    // window; a redirect arriving inside a window is squashed and ignored.
    assign cnt_load = (action == ACT_LOAD) && valid_i && redirect_i
                      && (SQUASH_N != 0);

    squash_counter #(
        .N     (SQUASH_N),
        .CNT_W (CNT_W)
    ) u_squash_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (action == ACT_FLUSH),
        .hold    (action == ACT_STALL),
        .load    (cnt_load),
        .cnt     (squash_cnt_o),
        .nonzero (squash_o)
    );

    always_ff @(posedge clk) begin
        unique case (action)
            ACT_RESET: begin
                valid_o <= 1'b0;
                ctrl_o  <= '0;
                data_o  <= '0;
            end
            ACT_FLUSH: begin
                // Payload is kept; only valid and control matter for a bubble.
                valid_o <= 1'b0;
                ctrl_o  <= '0;
            end
            ACT_STALL: begin
                valid_o <= valid_o;
            end
            ACT_SQUASH: begin
                valid_o <= 1'b0;
                ctrl_o  <= '0;
                data_o  <= data_i;
            end
            ACT_LOAD: begin
                valid_o <= valid_i;
                ctrl_o  <= valid_i ? ctrl_i : '0;
                data_o  <= data_i;
            end
            default: begin
                valid_o <= 1'b0;
                ctrl_o  <= '0;
            end
        endcase
    end

endmodule
